// File: rtl/conv_layer_single.sv
// conv_layer_single: 28x28 parallel 5x5 single-precision convolution, one filter tap per clock
module fp_mul (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] y_o
);
  function automatic logic [31:0] mul(input logic [31:0] a, input logic [31:0] b);
    logic s, az, bz, ai, bi, an, bn, g, st;
    logic [47:0] p;
    logic [9:0] e;
    logic [24:0] m;
    s = a[31] ^ b[31];
    az = a[30:23] == 8'd0;
    bz = b[30:23] == 8'd0;
    ai = a[30:23] == 8'hff && a[22:0] == 23'd0;
    bi = b[30:23] == 8'hff && b[22:0] == 23'd0;
    an = a[30:23] == 8'hff && a[22:0] != 23'd0;
    bn = b[30:23] == 8'hff && b[22:0] != 23'd0;
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = {2'b0, a[30:23]} + {2'b0, b[30:23]} + {9'd0, p[47]};
    m = p[47] ? {1'b0, p[47:24]} : {1'b0, p[46:23]};
    g = p[47] ? p[23] : p[22];
    st = p[47] ? |p[22:0] : |p[21:0];
    m = m + {24'd0, g & (st | m[0])};
    e = e + {9'd0, m[24]};
    if (an || bn) return 32'h7fc00000;
    if (ai || bi) return (az || bz) ? 32'h7fc00000 : {s, 8'hff, 23'd0};
    if (az || bz || e <= 10'd127) return {s, 31'd0};
    if (e >= 10'd382) return {s, 8'hff, 23'd0};
    e = e - 10'd127;
    return {s, e[7:0], m[24] ? m[23:1] : m[22:0]};
  endfunction
  assign y_o = mul(a_i, b_i);
endmodule

module fp_add (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] y_o
);
  function automatic logic [31:0] add(input logic [31:0] a, input logic [31:0] b);
    logic az, bz, ai, bi, an, bn;
    logic [31:0] x, y;
    logic [7:0] d;
    logic [26:0] mx, my, n;
    logic [49:0] t;
    logic [27:0] sm;
    logic [9:0] e;
    logic [4:0] lz;
    logic [24:0] m;
    az = a[30:23] == 8'd0;
    bz = b[30:23] == 8'd0;
    ai = a[30:23] == 8'hff && a[22:0] == 23'd0;
    bi = b[30:23] == 8'hff && b[22:0] == 23'd0;
    an = a[30:23] == 8'hff && a[22:0] != 23'd0;
    bn = b[30:23] == 8'hff && b[22:0] != 23'd0;
    if (an || bn) return 32'h7fc00000;
    if (ai && bi) return (a[31] != b[31]) ? 32'h7fc00000 : a;
    if (ai) return a;
    if (bi) return b;
    if (az && bz) return {a[31] & b[31], 31'd0};
    if (az) return b;
    if (bz) return a;
    x = a[30:0] < b[30:0] ? b : a;
    y = a[30:0] < b[30:0] ? a : b;
    d = x[30:23] - y[30:23];
    mx = {1'b1, x[22:0], 3'b0};
    t = {1'b1, y[22:0], 26'd0} >> d;
    my = d > 8'd26 ? 27'd1 : {t[49:24], t[23] | (|t[22:0])};
    sm = {1'b0, mx} + {1'b0, my};
    n = x[31] == y[31] ? (sm[27] ? {sm[27:2], sm[1] | sm[0]} : sm[26:0]) : mx - my;
    e = {2'b0, x[30:23]} + {9'd0, x[31] == y[31] && sm[27]};
    if (n == 27'd0) return 32'd0;
    lz = 5'd0;
    for (int i = 0; i < 26; i++)
      if (!n[26]) begin
        n = {n[25:0], 1'b0};
        lz = lz + 5'd1;
      end
    if ({5'd0, lz} >= e) return {x[31], 31'd0};
    e = e - {5'd0, lz};
    m = {1'b0, n[26:3]} + {24'd0, n[2] & (n[3] | n[1] | n[0])};
    e = e + {9'd0, m[24]};
    if (e >= 10'd255) return {x[31], 8'hff, 23'd0};
    return {x[31], e[7:0], m[24] ? m[23:1] : m[22:0]};
  endfunction
  assign y_o = add(a_i, b_i);
endmodule

module conv_layer_single (
  input  logic           clk,
  input  logic           reset,
  input  logic [32767:0] image,
  input  logic [799:0]   filter,
  output logic [25087:0] outputConv
);
  logic [4:0] k_q, k_d;
  logic [2:0] fr_q, fr_d, fc_q, fc_d;
  logic run;
  logic [9:0] off;
  logic [31:0] tap;
  // step the tap counter with its row/column split, saturating after tap 24
  always_comb begin
    run = k_q != 5'd25;
    k_d = run ? k_q + 5'd1 : k_q;
    fc_d = !run ? fc_q : (fc_q == 3'd4 ? 3'd0 : fc_q + 3'd1);
    fr_d = run && fc_q == 3'd4 ? fr_q + 3'd1 : fr_q;
    off = {2'b0, fr_q, 5'b0} + {7'b0, fc_q};
    tap = filter[{k_q, 5'b0} +: 32];
  end
  // tap counter register
  always_ff @(posedge clk) begin
    k_q <= reset ? 5'd0 : k_d;
    fr_q <= reset ? 3'd0 : fr_d;
    fc_q <= reset ? 3'd0 : fc_d;
  end
  for (genvar r = 0; r < 28; r++) begin : g_row
    for (genvar c = 0; c < 28; c++) begin : g_col
      logic [9:0] idx;
      logic [31:0] pix, prod, sum, acc_d, acc_q;
      assign idx = 10'(r * 32 + c) + off;
      assign pix = image[{idx, 5'b0} +: 32];
      fp_mul u_mul (.a_i(pix), .b_i(tap), .y_o(prod));
      fp_add u_add (.a_i(acc_q), .b_i(prod), .y_o(sum));
      assign acc_d = run ? sum : acc_q;
      // accumulator: cleared on reset, frozen once all taps are consumed
      always_ff @(posedge clk) acc_q <= reset ? 32'd0 : acc_d;
      assign outputConv[(r * 28 + c) * 32 +: 32] = acc_q;
    end
  end
endmodule

// File: tb/tb_conv_layer_single.sv
// tb_conv_layer_single: table-driven scoreboard bench for the convolution engine
module tb_conv_layer_single;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [32767:0] image;
  logic [799:0] filter;
  logic [25087:0] outputConv;
  int tests = 0;
  int failed = 0;
  logic [25087:0] exp_q[$];
  string nm_q[$];
  typedef struct {
    string name;
    int mode;
    logic [31:0] img;
    logic [31:0] flt;
    int edges;
    logic [31:0] want;
  } vec_t;
  vec_t vecs[10];

  conv_layer_single dut (.clk(clk), .reset(reset), .image(image), .filter(filter), .outputConv(outputConv));

  always #5 clk = ~clk;

  function automatic logic [31:0] i2f(input int v);
    int p;
    logic [31:0] w;
    if (v == 0) return 32'd0;
    p = 0;
    for (int i = 0; i < 24; i++) if ((v >> i) != 0) p = i;
    w = 32'(v) << (23 - p);
    return {1'b0, 8'(127 + p), w[22:0]};
  endfunction

  function automatic logic [25087:0] fill(input logic [31:0] w);
    logic [25087:0] e;
    for (int i = 0; i < 784; i++) e[i*32 +: 32] = w;
    return e;
  endfunction

  function automatic logic [25087:0] shifted();
    logic [25087:0] e;
    for (int r = 0; r < 28; r++)
      for (int c = 0; c < 28; c++) e[(r*28+c)*32 +: 32] = i2f((r + 2) * 32 + c + 2);
    return e;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input string nm, input logic [25087:0] e);
    exp_q.push_back(e);
    nm_q.push_back(nm);
  endtask

  task automatic check();
    logic [25087:0] e;
    string nm;
    int idx;
    e = exp_q.pop_front();
    nm = nm_q.pop_front();
    tests++;
    if (outputConv !== e) begin
      idx = 0;
      for (int i = 783; i >= 0; i--) if (outputConv[i*32 +: 32] !== e[i*32 +: 32]) idx = i;
      failed++;
      $display("FAIL %s: pixel %0d got %h want %h", nm, idx, outputConv[idx*32 +: 32], e[idx*32 +: 32]);
    end
  endtask

  task automatic run_vec(input vec_t v);
    if (v.mode == 0) begin
      image = {1024{v.img}};
      filter = {25{v.flt}};
    end else if (v.mode == 1) begin
      for (int i = 0; i < 1024; i++) image[i*32 +: 32] = i2f(i);
      filter = '0;
      filter[12*32 +: 32] = 32'h3f800000;
    end else begin
      for (int i = 0; i < 1024; i++)
        image[i*32 +: 32] = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 23'($urandom)};
      filter = '0;
    end
    reset = 1'b1;
    tick(1);
    push({v.name, "/reset"}, '0);
    check();
    reset = 1'b0;
    push(v.name, (v.mode == 1 && v.edges >= 13) ? shifted() : fill(v.want));
    tick(v.edges);
    check();
  endtask

  initial begin
    vecs[0] = '{"all4_e1",   0, 32'h40800000, 32'h40800000, 1,  32'h41800000};
    vecs[1] = '{"all4_e5",   0, 32'h40800000, 32'h40800000, 5,  32'h42a00000};
    vecs[2] = '{"all4_e10",  0, 32'h40800000, 32'h40800000, 10, 32'h43200000};
    vecs[3] = '{"all4_e25",  0, 32'h40800000, 32'h40800000, 25, 32'h43c80000};
    vecs[4] = '{"all4_e27",  0, 32'h40800000, 32'h40800000, 27, 32'h43c80000};
    vecs[5] = '{"sign_e27",  0, 32'h40000000, 32'hbf800000, 27, 32'hc2480000};
    vecs[6] = '{"shift_e12", 1, 32'h0,        32'h0,        12, 32'h00000000};
    vecs[7] = '{"shift_e27", 1, 32'h0,        32'h0,        27, 32'h00000000};
    vecs[8] = '{"zero_e13",  2, 32'h0,        32'h0,        13, 32'h00000000};
    vecs[9] = '{"zero_e27",  2, 32'h0,        32'h0,        27, 32'h00000000};
    image = '0;
    filter = '0;
    for (int i = 0; i < 10; i++) run_vec(vecs[i]);
    image = {1024{32'h40800000}};
    filter = {25{32'h40800000}};
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    push("mid_before", fill(32'h43300000));
    tick(11);
    check();
    reset = 1'b1;
    push("mid_reset", '0);
    tick(1);
    check();
    reset = 1'b0;
    push("mid_e24", fill(32'h43c00000));
    tick(24);
    check();
    push("mid_e25", fill(32'h43c80000));
    tick(1);
    check();
    push("mid_hold", fill(32'h43c80000));
    tick(30);
    check();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/conv_layer_single.md
# conv_layer_single

Single-channel 2-D convolution engine. It convolves a 32×32 IEEE-754 single-precision image with a 5×5 filter (valid mode, stride 1) and produces a 28×28 float feature map. All 784 output pixels are computed in parallel, one filter tap per clock, so a full result is available 25 cycles after reset is released. It sits in the CNN datapath as the convolution stage that feeds the pooling and activation stages.

## Interface
- No parameters. Sizes are fixed: image 32×32, filter 5×5, output 28×28, 32-bit floats.
- clk  input  1  Rising-edge clock; the block's only clock.
- reset  input  1  Synchronous, active-high. Clears all accumulators and the tap counter.
- image  input  32768  1024 floats, row-major. Pixel (r,c) is at bits [(r*32+c)*32 +: 32].
- filter  input  800  25 floats, row-major. Tap (fr,fc) is at bits [(fr*5+fc)*32 +: 32].
- outputConv  output  25088  784 floats, row-major. Output (r,c) is at bits [(r*28+c)*32 +: 32]. This is a direct register output.

## Operation
- Output definition: out(r,c) = Σ over fr,fc in 0..4 of image(r+fr, c+fc) × filter(fr,fc), for r,c in 0..27.
- Structure:
  - 784 identical processing elements (PEs), one per output pixel, built with a generate loop.
  - Each PE has one floating-point multiplier, one floating-point adder and a 32-bit accumulator register.
  - The multiplier and adder are the codebase's existing single-precision modules.
- Control: a shared tap counter k runs 0..25 and saturates at 25. Tap k maps to fr = k/5, fc = k%5.
- Each clock while reset = 0 and k < 25:
  - every PE does acc ← acc + image(r+fr, c+fc) × filter(fr,fc);
  - then k ← k+1.
- When k = 25 the accumulators hold their values until the next reset.
- Arithmetic:
  - IEEE-754 single precision, round-to-nearest-even.
  - The product is rounded, then the sum is rounded. There is no fused operation.
  - Accumulation order is fixed, k = 0..24, starting from acc = +0.0.
- Special values: NaN and Inf propagate per IEEE. Denormals are flushed to zero.
- outputConv is the concatenation of all accumulators at all times, so partial sums are visible during the computation.
- image and filter must be held stable from reset release until k reaches 25. A change mid-run affects only the taps processed after the change.

## Timing
- Reset: on any rising edge with reset = 1, all accumulators become 0x00000000 and k becomes 0. This applies mid-computation too, which aborts the run and restarts from zero.
- Latency:
  - After the n-th rising edge with reset = 0 (n ≤ 25), each output equals the rounded partial sum of taps 0..n-1.
  - The final result is valid after the 25th such edge and stays stable indefinitely.
- There is no handshake or done signal. The consumer waits at least 25 cycles after reset deasserts; the system schedules 27.
- The multiply-add path is combinational within one cycle, so the clock period must cover multiplier plus adder delay.

## Test plan
- All 4.0: every image pixel and filter tap = 0x40800000. Release reset and wait 27 cycles. Every output = 400.0 = 0x43C80000.
- Partial sums: same stimulus, sampled after 10 edges post-reset. Every output = 160.0 = 0x43200000.
- Shift filter: centre tap (2,2) = 1.0 (0x3F800000), all other taps = 0.0; image(r,c) = float(r*32+c). Every out(r,c) = float((r+2)*32 + c + 2); for example, out(0,0) = 66.0 = 0x42840000.
- Sign: image all 2.0 (0x40000000), filter all −1.0 (0xBF800000). Every output = −50.0 = 0xC2480000.
- Reset mid-run: all-4.0 stimulus, reassert reset at edge 12 for one cycle, then release.
  - All outputs read 0x00000000 immediately after the reset edge.
  - All outputs read 0x43C80000 25 edges after the release.
- Zero filter with an arbitrary image: all outputs stay 0x00000000 for the whole run.
